cache2v_seq_ctrl: RTL and testbench



---
 rtl/cache2v_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_cache2v_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache2v_seq_ctrl.sv
// Sequencing controller for a 2-way set-associative write-back cache, one word per line.
// Latency from acceptance: hit 2, clean load miss 4, dirty load miss 5, clean store miss 3, dirty store miss 4.
// Backpressure: req_ready is high only in IDLE; req_valid is ignored while a request is in flight.
module cache2v_seq_ctrl #(
    parameter int TAG_W  = 3,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic [IDX_W-1:0]        req_index,
    input  logic [DATA_W-1:0]       req_data,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [DATA_W-1:0]       resp_data,
    output logic [IDX_W:0]          cache_addr,
    output logic                    cache_wren,
    output logic [DATA_W-1:0]       cache_wdata,
    input  logic [DATA_W-1:0]       cache_rdata,
    output logic [TAG_W+IDX_W-1:0]  ram_address,
    output logic                    ram_wren,
    output logic [DATA_W-1:0]       ram_data,
    input  logic [DATA_W-1:0]       ram_q,
    output logic                    writeback,
    output logic                    hit
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL, S_FILL_WAIT, S_ALLOC, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic                wr_q;
    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdat_q;
    logic                victim_q, victim_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;

    logic [SETS-1:0]     valid0_q, valid1_q, dirty0_q, dirty1_q, lru_q;
    logic [TAG_W-1:0]    tag0_q [SETS];
    logic [TAG_W-1:0]    tag1_q [SETS];

    logic                v0, v1, hit0, hit1, any_hit, hit_way;
    logic                miss_victim, miss_dirty;
    logic [TAG_W-1:0]    victim_tag;

    logic                line_we, line_dirty;
    logic                dirty_we, dirty_way, dirty_val;
    logic                lru_we, lru_val;

    assign v0         = valid0_q[idx_q];
    assign v1         = valid1_q[idx_q];
    assign hit0       = v0 && (tag0_q[idx_q] == tag_q);
    assign hit1       = v1 && (tag1_q[idx_q] == tag_q);
    assign any_hit    = hit0 || hit1;
    assign hit_way    = !hit0;
    // Prefer an empty way before evicting the least-recently-used one.
    assign miss_victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[idx_q]);
    assign miss_dirty  = miss_victim ? (v1 && dirty1_q[idx_q]) : (v0 && dirty0_q[idx_q]);
    assign victim_tag  = victim_q ? tag1_q[idx_q] : tag0_q[idx_q];
    assign resp_data   = rdat_q;

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        hit_d       = hit_q;
        rdat_d      = rdat_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        cache_addr  = '0;
        cache_wren  = 1'b0;
        cache_wdata = '0;
        ram_address = '0;
        ram_wren    = 1'b0;
        ram_data    = '0;
        writeback   = 1'b0;
        hit         = 1'b0;
        line_we     = 1'b0;
        line_dirty  = 1'b0;
        dirty_we    = 1'b0;
        dirty_way   = 1'b0;
        dirty_val   = 1'b0;
        lru_we      = 1'b0;
        lru_val     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                hit   = any_hit;
                hit_d = any_hit;
                if (any_hit) begin
                    cache_addr = {hit_way, idx_q};
                    lru_we     = 1'b1;
                    lru_val    = !hit_way;
                    if (wr_q) begin
                        cache_wren  = 1'b1;
                        cache_wdata = wdat_q;
                        dirty_we    = 1'b1;
                        dirty_way   = hit_way;
                        dirty_val   = 1'b1;
                        rdat_d      = wdat_q;
                    end else begin
                        rdat_d = cache_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    victim_d = miss_victim;
                    if (miss_dirty)  state_d = S_WB;
                    else if (wr_q)   state_d = S_ALLOC;
                    else             state_d = S_FILL;
                end
            end
            S_WB: begin
                cache_addr  = {victim_q, idx_q};
                ram_address = {victim_tag, idx_q};
                ram_data    = cache_rdata;
                ram_wren    = 1'b1;
                writeback   = 1'b1;
                dirty_we    = 1'b1;
                dirty_way   = victim_q;
                dirty_val   = 1'b0;
                state_d     = wr_q ? S_ALLOC : S_FILL;
            end
            S_FILL: begin
                ram_address = {tag_q, idx_q};
                state_d     = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                cache_addr  = {victim_q, idx_q};
                cache_wren  = 1'b1;
                cache_wdata = ram_q;
                rdat_d      = ram_q;
                line_we     = 1'b1;
                line_dirty  = 1'b0;
                lru_we      = 1'b1;
                lru_val     = !victim_q;
                state_d     = S_RESP;
            end
            S_ALLOC: begin
                cache_addr  = {victim_q, idx_q};
                cache_wren  = 1'b1;
                cache_wdata = wdat_q;
                rdat_d      = wdat_q;
                line_we     = 1'b1;
                line_dirty  = 1'b1;
                lru_we      = 1'b1;
                lru_val     = !victim_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An aborted request must not leave a stray write on either array.
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_hit   = 1'b0;
            cache_wren = 1'b0;
            ram_wren   = 1'b0;
            writeback  = 1'b0;
            hit        = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            tag_q    <= '0;
            idx_q    <= '0;
            wdat_q   <= '0;
            victim_q <= 1'b0;
            hit_q    <= 1'b0;
            rdat_q   <= '0;
            valid0_q <= '0;
            valid1_q <= '0;
            dirty0_q <= '0;
            dirty1_q <= '0;
            lru_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag0_q[s] <= '0;
                tag1_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            hit_q    <= hit_d;
            rdat_q   <= rdat_d;
            if (req_valid && req_ready) begin
                wr_q   <= req_write;
                tag_q  <= req_tag;
                idx_q  <= req_index;
                wdat_q <= req_data;
            end
            if (dirty_we) begin
                if (dirty_way) dirty1_q[idx_q] <= dirty_val;
                else           dirty0_q[idx_q] <= dirty_val;
            end
            if (line_we) begin
                if (victim_q) begin
                    valid1_q[idx_q] <= 1'b1;
                    tag1_q[idx_q]   <= tag_q;
                    dirty1_q[idx_q] <= line_dirty;
                end else begin
                    valid0_q[idx_q] <= 1'b1;
                    tag0_q[idx_q]   <= tag_q;
                    dirty0_q[idx_q] <= line_dirty;
                end
            end
            if (lru_we) lru_q[idx_q] <= lru_val;
        end
    end

endmodule

// File: tb/tb_cache2v_seq_ctrl.sv
// Directed bench for cache2v_seq_ctrl with behavioural data-array and RAM models.
module tb_cache2v_seq_ctrl;

    logic       clock, reset;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_tag;
    logic [1:0] req_index;
    logic [7:0] req_data;
    logic       resp_valid, resp_hit;
    logic [7:0] resp_data;
    logic [2:0] cache_addr;
    logic       cache_wren;
    logic [7:0] cache_wdata, cache_rdata;
    logic [4:0] ram_address;
    logic       ram_wren;
    logic [7:0] ram_data, ram_q;
    logic       writeback, hit;

    logic       mem_init;
    logic [7:0] ram_mem [32];
    logic [7:0] cmem [8];

    int checks = 0;
    int errors = 0;

    cache2v_seq_ctrl #(.TAG_W(3), .IDX_W(2), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_index(req_index), .req_data(req_data),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .cache_addr(cache_addr), .cache_wren(cache_wren), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
        .writeback(writeback), .hit(hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] ram_init_val(input int a);
        if (a == 8)      return 8'h21;
        else if (a == 0) return 8'h05;
        else             return 8'(a) ^ 8'hA5;
    endfunction

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= ram_init_val(i);
            for (int i = 0; i < 8; i++)  cmem[i] <= 8'h00;
        end else begin
            if (ram_wren)   ram_mem[ram_address] <= ram_data;
            if (cache_wren) cmem[cache_addr] <= cache_wdata;
        end
        ram_q <= ram_mem[ram_address];
    end
    assign cache_rdata = cmem[cache_addr];

    typedef struct {
        logic       wr;
        logic [2:0] tag;
        logic [1:0] idx;
        logic [7:0] dat;
        logic       exp_hit;
        logic [7:0] exp_dat;
        int         exp_lat;
        int         exp_wb;
        logic [4:0] exp_wb_addr;
        logic [7:0] exp_wb_dat;
        int         exp_cwr;
        logic [2:0] exp_caddr;
        logic       chk_fill;
        logic [4:0] exp_fill;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic wr, input logic [2:0] tag, input logic [1:0] idx,
                                input logic [7:0] dat, input logic eh, input logic [7:0] ed,
                                input int lat, input int wb, input logic [4:0] wa,
                                input logic [7:0] wd, input int cw, input logic [2:0] ca,
                                input logic cf, input logic [4:0] fa);
        vec_t v;
        v.wr = wr; v.tag = tag; v.idx = idx; v.dat = dat;
        v.exp_hit = eh; v.exp_dat = ed; v.exp_lat = lat;
        v.exp_wb = wb; v.exp_wb_addr = wa; v.exp_wb_dat = wd;
        v.exp_cwr = cw; v.exp_caddr = ca; v.chk_fill = cf; v.exp_fill = fa;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            guard++;
            @(negedge clock);
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int lat = 0, wbc = 0, rwc = 0, cwc = 0, hc = 0;
        logic [4:0] wb_a = '0, fa = '0, prev_ra = '0;
        logic [7:0] wb_d = '0, r_dat = '0;
        logic [2:0] ca = '0;
        logic r_hit = 1'b0;
        bit done = 0;
        string p;
        p = $sformatf("v%0d", n);
        req_write = v.wr; req_tag = v.tag; req_index = v.idx; req_data = v.dat;
        req_valid = 1'b1;
        wait_ready(p);
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
            if (writeback) wbc++;
            if (hit) hc++;
            if (ram_wren) begin rwc++; wb_a = ram_address; wb_d = ram_data; end
            if (cache_wren) begin cwc++; ca = cache_addr; fa = prev_ra; end
            prev_ra = ram_address;
            if (resp_valid) begin done = 1; r_hit = resp_hit; r_dat = resp_data; end
        end
        if (!done) chk({p, "_resp_timeout"}, 32'd0, 32'd1);
        chk({p, "_hit"}, 32'(r_hit), 32'(v.exp_hit));
        chk({p, "_data"}, 32'(r_dat), 32'(v.exp_dat));
        chk({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({p, "_hit_out_cycles"}, 32'(hc), 32'(v.exp_hit));
        chk({p, "_writeback_cycles"}, 32'(wbc), 32'(v.exp_wb));
        chk({p, "_ram_writes"}, 32'(rwc), 32'(v.exp_wb));
        chk({p, "_cache_writes"}, 32'(cwc), 32'(v.exp_cwr));
        if (v.exp_wb > 0) begin
            chk({p, "_wb_addr"}, 32'(wb_a), 32'(v.exp_wb_addr));
            chk({p, "_wb_data"}, 32'(wb_d), 32'(v.exp_wb_dat));
        end
        if (v.exp_cwr > 0) chk({p, "_cache_addr"}, 32'(ca), 32'(v.exp_caddr));
        if (v.chk_fill) chk({p, "_fill_addr"}, 32'(fa), 32'(v.exp_fill));
        @(negedge clock);
        chk({p, "_resp_hold"}, 32'(resp_data), 32'(v.exp_dat));
        chk({p, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int rcnt, acc, t1, t2, sw;
        logic [7:0] rd [2];

        vecs[0]  = mk(0, 3'b010, 2'd0, 8'h00, 0, 8'h21, 4, 0, 5'd0, 8'h00, 1, 3'd0, 1, 5'b01000);
        vecs[1]  = mk(0, 3'b010, 2'd0, 8'h00, 1, 8'h21, 2, 0, 5'd0, 8'h00, 0, 3'd0, 0, 5'd0);
        vecs[2]  = mk(1, 3'b100, 2'd0, 8'h0F, 0, 8'h0F, 3, 0, 5'd0, 8'h00, 1, 3'd4, 0, 5'd0);
        vecs[3]  = mk(1, 3'b111, 2'd0, 8'h12, 0, 8'h12, 3, 0, 5'd0, 8'h00, 1, 3'd0, 0, 5'd0);
        vecs[4]  = mk(0, 3'b000, 2'd0, 8'h00, 0, 8'h05, 5, 1, 5'b10000, 8'h0F, 1, 3'd4, 1, 5'b00000);
        vecs[5]  = mk(0, 3'b100, 2'd0, 8'h00, 0, 8'h0F, 5, 1, 5'b11100, 8'h12, 1, 3'd0, 1, 5'b10000);
        vecs[6]  = mk(0, 3'b111, 2'd0, 8'h00, 0, 8'h12, 4, 0, 5'd0, 8'h00, 1, 3'd4, 1, 5'b11100);
        vecs[7]  = mk(1, 3'b111, 2'd0, 8'h77, 1, 8'h77, 2, 0, 5'd0, 8'h00, 1, 3'd4, 0, 5'd0);
        vecs[8]  = mk(0, 3'b111, 2'd0, 8'h00, 1, 8'h77, 2, 0, 5'd0, 8'h00, 0, 3'd0, 0, 5'd0);
        vecs[9]  = mk(0, 3'b101, 2'd3, 8'h00, 0, 8'hB2, 4, 0, 5'd0, 8'h00, 1, 3'd3, 1, 5'b10111);
        vecs[10] = mk(1, 3'b101, 2'd3, 8'h3C, 1, 8'h3C, 2, 0, 5'd0, 8'h00, 1, 3'd3, 0, 5'd0);
        vecs[11] = mk(0, 3'b100, 2'd0, 8'h00, 1, 8'h0F, 2, 0, 5'd0, 8'h00, 0, 3'd0, 0, 5'd0);
        vecs[12] = mk(0, 3'b111, 2'd0, 8'h00, 0, 8'h12, 4, 0, 5'd0, 8'h00, 1, 3'd0, 1, 5'b11100);

        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_tag = '0; req_index = '0; req_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; mem_init = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_enables", 32'({cache_wren, ram_wren}), 32'd0);
        chk("rst_wb_hit", 32'({writeback, hit}), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Abort a load in FILL_WAIT.
        req_write = 1'b0; req_tag = 3'b011; req_index = 2'd1; req_data = 8'h00;
        req_valid = 1'b1;
        wait_ready("abort");
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("abort_cache_wren", 32'(cache_wren), 32'd0);
        chk("abort_ram_wren", 32'(ram_wren), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_resp_data", 32'(resp_data), 32'd0);
        rcnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) rcnt++;
            @(negedge clock);
        end
        chk("abort_no_resp", 32'(rcnt), 32'd0);
        run_vec(12, vecs[12]);

        // Request held high across a busy controller.
        rcnt = 0; acc = 0; t1 = -1; t2 = -1; sw = 0;
        rd[0] = '0; rd[1] = '0;
        req_write = 1'b0; req_tag = 3'b010; req_index = 2'd0; req_data = 8'h00;
        req_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clock);
            if (sw == 1) begin
                if (acc == 1) begin req_tag = 3'b101; req_index = 2'd2; end
                else          req_valid = 1'b0;
                sw = 0;
            end
            if (resp_valid) begin
                if (rcnt < 2) rd[rcnt] = resp_data;
                rcnt++;
            end
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 1) t1 = c; else t2 = c;
                sw = 1;
            end
        end
        chk("hold_accepts", 32'(acc), 32'd2);
        chk("hold_resp_count", 32'(rcnt), 32'd2);
        chk("hold_accept_gap", 32'(t2 - t1), 32'd5);
        chk("hold_resp0_data", 32'(rd[0]), 32'h21);
        chk("hold_resp1_data", 32'(rd[1]), 32'hB3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
